// File: rtl/tx_pkg.sv
// Shared types and constants for the packet transmit controller.
// TX_CRC16_EN selects the built-in CRC16 generator and its two CRC states.
package tx_pkg;

`ifdef TX_CRC16_EN
    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, EOP, DONE
    } tx_state_t;
`endif

    localparam logic [7:0]  SYNC_BYTE     = 8'h80;
    localparam logic [1:0]  PID_TYPE_HSK  = 2'b10;
    localparam logic [1:0]  PID_TYPE_DATA = 2'b11;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REF  = 16'hA001;

    // Reflected CRC16 (0x8005), one whole byte per call, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ CRC_POLY_REF;
            else      c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_crc16.sv
// Running USB CRC16 over the payload, updated one byte per enabled cycle.
// Only instantiated when TX_CRC16_EN is defined.
module tx_crc16
    import tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= CRC_INIT;
        end else if (clr) begin
            crc_reg <= CRC_INIT;
        end else if (en) begin
            crc_reg <= crc16_byte(crc_reg, data);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/tx_controller.sv
// Packet transmit sequencer: SYNC, PID, payload, optional CRC16, then EOP.
// Define TX_CRC16_EN to append a generated CRC16; otherwise upstream supplies it.
module tx_controller
    import tx_pkg::*;
#(
    parameter int MAX_PKT_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_pop,
    input  logic       byte_done,
    input  logic       bit_done,
    output logic       timer_en,
    output logic       timer_clr,
    output logic       load_byte,
    output logic [7:0] tx_byte,
    output logic       eop_req,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

`ifdef TX_CRC16_EN
    localparam int PAYLOAD_LIMIT = MAX_PKT_BYTES;
    localparam int CNT_W         = $clog2(MAX_PKT_BYTES + 1);
`else
    // Counter also covers the two CRC bytes streamed from the FIFO.
    localparam int PAYLOAD_LIMIT = MAX_PKT_BYTES + 2;
    localparam int CNT_W         = $clog2(MAX_PKT_BYTES + 3);
`endif
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(PAYLOAD_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    tx_state_t        state_reg, state_next;
    logic [3:0]       pid_reg, pid_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       eop_bits_reg, eop_bits_next;

    logic       fifo_pop_reg,  fifo_pop_next;
    logic       timer_en_reg,  timer_en_next;
    logic       timer_clr_reg, timer_clr_next;
    logic       load_byte_reg, load_byte_next;
    logic [7:0] tx_byte_reg,   tx_byte_next;
    logic       eop_req_reg,   eop_req_next;
    logic       tx_busy_reg,   tx_busy_next;
    logic       tx_done_reg,   tx_done_next;
    logic       tx_error_reg,  tx_error_next;

    logic start_ok;
    logic more_payload;

    assign start_ok     = (tx_pid[1:0] == PID_TYPE_DATA) || (tx_pid[1:0] == PID_TYPE_HSK);
    assign more_payload = !fifo_empty && (cnt_reg < CNT_LIMIT);

`ifdef TX_CRC16_EN
    logic [15:0] crc_val;

    // Each popped byte enters the CRC in the cycle it is loaded.
    tx_crc16 u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr_next),
        .en   (fifo_pop_next),
        .data (fifo_rdata),
        .crc  (crc_val)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pid_reg       <= 4'h0;
            cnt_reg       <= '0;
            eop_bits_reg  <= 2'd0;
            fifo_pop_reg  <= 1'b0;
            timer_en_reg  <= 1'b0;
            timer_clr_reg <= 1'b0;
            load_byte_reg <= 1'b0;
            tx_byte_reg   <= 8'h00;
            eop_req_reg   <= 1'b0;
            tx_busy_reg   <= 1'b0;
            tx_done_reg   <= 1'b0;
            tx_error_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pid_reg       <= pid_next;
            cnt_reg       <= cnt_next;
            eop_bits_reg  <= eop_bits_next;
            fifo_pop_reg  <= fifo_pop_next;
            timer_en_reg  <= timer_en_next;
            timer_clr_reg <= timer_clr_next;
            load_byte_reg <= load_byte_next;
            tx_byte_reg   <= tx_byte_next;
            eop_req_reg   <= eop_req_next;
            tx_busy_reg   <= tx_busy_next;
            tx_done_reg   <= tx_done_next;
            tx_error_reg  <= tx_error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pid_next       = pid_reg;
        cnt_next       = cnt_reg;
        eop_bits_next  = eop_bits_reg;
        tx_byte_next   = tx_byte_reg;
        fifo_pop_next  = 1'b0;
        timer_clr_next = 1'b0;
        load_byte_next = 1'b0;
        tx_error_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tx_start) begin
                    if (start_ok) begin
                        state_next     = SYNC;
                        pid_next       = tx_pid;
                        cnt_next       = '0;
                        timer_clr_next = 1'b1;
                        load_byte_next = 1'b1;
                        tx_byte_next   = SYNC_BYTE;
                    end else begin
                        tx_error_next  = 1'b1;
                    end
                end
            end
            SYNC: begin
                if (byte_done) begin
                    state_next     = PID;
                    load_byte_next = 1'b1;
                    tx_byte_next   = {~pid_reg, pid_reg};
                end
            end
            PID: begin
                if (byte_done) begin
                    if (pid_reg[1:0] == PID_TYPE_HSK) begin
                        state_next = EOP;
                    end else if (!fifo_empty) begin
                        state_next     = DATA;
                        load_byte_next = 1'b1;
                        fifo_pop_next  = 1'b1;
                        tx_byte_next   = fifo_rdata;
                        cnt_next       = cnt_reg + CNT_ONE;
                    end else begin
`ifdef TX_CRC16_EN
                        state_next     = CRC_LO;
                        load_byte_next = 1'b1;
                        tx_byte_next   = ~crc_val[7:0];
`else
                        state_next     = EOP;
`endif
                    end
                end
            end
            DATA: begin
                if (byte_done) begin
                    if (more_payload) begin
                        load_byte_next = 1'b1;
                        fifo_pop_next  = 1'b1;
                        tx_byte_next   = fifo_rdata;
                        cnt_next       = cnt_reg + CNT_ONE;
                    end else begin
`ifdef TX_CRC16_EN
                        state_next     = CRC_LO;
                        load_byte_next = 1'b1;
                        tx_byte_next   = ~crc_val[7:0];
`else
                        state_next     = EOP;
`endif
                    end
                end
            end
`ifdef TX_CRC16_EN
            CRC_LO: begin
                if (byte_done) begin
                    state_next     = CRC_HI;
                    load_byte_next = 1'b1;
                    tx_byte_next   = ~crc_val[15:8];
                end
            end
            CRC_HI: begin
                if (byte_done) begin
                    state_next = EOP;
                end
            end
`endif
            EOP: begin
                // Line is held in EOP for three bit times.
                if (bit_done) begin
                    if (eop_bits_reg == 2'd2) begin
                        state_next    = DONE;
                        eop_bits_next = 2'd0;
                    end else begin
                        eop_bits_next = eop_bits_reg + 2'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        timer_en_next = (state_next != IDLE) && (state_next != DONE);
        eop_req_next  = (state_next == EOP);
        tx_busy_next  = (state_next != IDLE);
        tx_done_next  = (state_next == DONE);
    end

    assign fifo_pop  = fifo_pop_reg;
    assign timer_en  = timer_en_reg;
    assign timer_clr = timer_clr_reg;
    assign load_byte = load_byte_reg;
    assign tx_byte   = tx_byte_reg;
    assign eop_req   = eop_req_reg;
    assign tx_busy   = tx_busy_reg;
    assign tx_done   = tx_done_reg;
    assign tx_error  = tx_error_reg;

endmodule

// File: tb/tb_tx_controller.sv
// Scoreboard bench for tx_controller: expected tx_byte loads are queued by the
// stimulus and consumed by a negedge monitor. Honours TX_CRC16_EN like the RTL.
module tb_tx_controller;

    localparam int MAXB = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_pop;
    logic       byte_done;
    logic       bit_done;
    logic       timer_en;
    logic       timer_clr;
    logic       load_byte;
    logic [7:0] tx_byte;
    logic       eop_req;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int pop_cnt  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int eop_bits = 0;
    int tcnt     = 0;

    always #5 clk = ~clk;

    tx_controller #(.MAX_PKT_BYTES(MAXB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_pid     (tx_pid),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .byte_done  (byte_done),
        .bit_done   (bit_done),
        .timer_en   (timer_en),
        .timer_clr  (timer_clr),
        .load_byte  (load_byte),
        .tx_byte    (tx_byte),
        .eop_req    (eop_req),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Bit-serial reference CRC16 (reflected 0x8005, init FFFF), not complemented.
    function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (q[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ q[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    // FIFO and tx_timer models, driven 1ns after the active edge.
    always @(posedge clk) begin
        #1;
        if (fifo_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
        if (!timer_en || timer_clr) tcnt = 0;
        else                        tcnt++;
        byte_done = timer_en && (tcnt % 6 == 5);
        bit_done  = timer_en && (tcnt % 2 == 1);
    end

    // Monitor: consumes one expected byte per load_byte strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (load_byte) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_load: got tx_byte=%0h required no load", tx_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tx_byte", int'(tx_byte), int'(mon_exp));
                end
            end
            if (fifo_pop) begin
                pop_cnt++;
                check("pop_with_load", int'(load_byte), 1);
            end
            if (eop_req && bit_done) eop_bits++;
            if (tx_error) err_cnt++;
            check("busy", int'(tx_busy), int'(timer_en | tx_done));
            if (tx_done) begin
                done_cnt++;
                check("eop_bit_times", eop_bits, 3);
                check("bytes_outstanding", exp_q.size(), 0);
                eop_bits = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [3:0] pid);
        tx_start = 1'b1;
        tx_pid   = pid;
        tick(1);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            tick(1);
            n++;
        end
        check(name, done_cnt, target);
    endtask

    task automatic wait_pops(input int target, input string name);
        int n = 0;
        while (pop_cnt < target && n < 3000) begin
            tick(1);
            n++;
        end
        check(name, int'(pop_cnt >= target), 1);
    endtask

    task automatic run_ack(input string name);
        int target;
        target = done_cnt + 1;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hD2);
        start(4'b0010);
        wait_done(target, {name, "_done"});
        tick(40);
        check({name, "_single_done"}, done_cnt, target);
        $display("packet %s: pid=2 done_count=%0d", name, done_cnt);
    endtask

    // Data packet with n payload bytes 01,02,...; pid_byte is the hand-computed PID byte.
    task automatic run_data(input logic [3:0] pid, input logic [7:0] pid_byte,
                            input int n, input bit inject, input string name);
        logic [7:0]  pl[$];
        logic [7:0]  sq[$];
        logic [15:0] c;
        int sent, pops0, target, stream_len;
        pl = {};
        sq = {};
        for (int i = 0; i < n; i++) pl.push_back(8'(i + 1));
        exp_q.push_back(8'h80);
        exp_q.push_back(pid_byte);
`ifdef TX_CRC16_EN
        foreach (pl[i]) fifo_q.push_back(pl[i]);
        stream_len = n;
        sent = (n < MAXB) ? n : MAXB;
        for (int i = 0; i < sent; i++) sq.push_back(pl[i]);
        c = ~crc_ref(sq);
        foreach (sq[i]) exp_q.push_back(sq[i]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
`else
        sq = pl;
        if (n > 0) begin
            c = ~crc_ref(pl);
            sq.push_back(c[7:0]);
            sq.push_back(c[15:8]);
        end
        foreach (sq[i]) fifo_q.push_back(sq[i]);
        stream_len = sq.size();
        sent = (stream_len < MAXB + 2) ? stream_len : MAXB + 2;
        for (int i = 0; i < sent; i++) exp_q.push_back(sq[i]);
`endif
        pops0  = pop_cnt;
        target = done_cnt + 1;
        tick(2);
        start(pid);
        if (inject) begin
            wait_pops(pops0 + 1, {name, "_reach_data"});
            start(4'b0010);
        end
        wait_done(target, {name, "_done"});
        tick(40);
        check({name, "_single_done"}, done_cnt, target);
        check({name, "_pops"}, pop_cnt - pops0, sent);
        check({name, "_fifo_left"}, fifo_q.size(), stream_len - sent);
        $display("packet %s: pid=%0h payload=%0d pops=%0d left=%0d", name, pid, n,
                 pop_cnt - pops0, fifo_q.size());
        fifo_q.delete();
        tick(2);
    endtask

    initial begin
        int err0, done0, pops0;
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_pid   = 4'h0;
        tick(3);
        check("rst_outputs", int'({fifo_pop, timer_en, timer_clr, load_byte,
                                   eop_req, tx_busy, tx_done, tx_error}), 0);
        check("rst_tx_byte", int'(tx_byte), 0);
        rst = 1'b0;
        tick(2);

        run_ack("ack");
        run_data(4'b0011, 8'hC3, 3, 1'b0, "data0_3");
        run_data(4'b1011, 8'h4B, 0, 1'b0, "data1_empty");
        run_data(4'b0011, 8'hC3, 70, 1'b0, "data0_70");

        err0 = err_cnt;
        start(4'b0001);
        check("illegal_busy", int'(tx_busy), 0);
        tick(3);
        check("illegal_error_pulses", err_cnt - err0, 1);
        check("illegal_idle_busy", int'(tx_busy), 0);
        $display("packet illegal: pid=1 error_pulses=%0d", err_cnt - err0);

        run_data(4'b0011, 8'hC3, 5, 1'b1, "data0_restart_ignored");

        // Abort mid-payload with an asynchronous reset between clock edges.
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'hA0 + i));
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'hA0 + i));
        done0 = done_cnt;
        pops0 = pop_cnt;
        tick(2);
        start(4'b0011);
        wait_pops(pops0 + 3, "abort_reach_data");
        #2;
        rst = 1'b1;
        #1;
        check("abort_outputs", int'({fifo_pop, timer_en, timer_clr, load_byte,
                                     eop_req, tx_busy, tx_done, tx_error}), 0);
        check("abort_tx_byte", int'(tx_byte), 0);
        exp_q.delete();
        fifo_q.delete();
        eop_bits = 0;
        tick(3);
        rst = 1'b0;
        tick(30);
        check("abort_no_done", done_cnt, done0);
        $display("packet abort: reset during payload, done_count=%0d", done_cnt);

        run_ack("ack_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
